// File: rtl/four_bit_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load per clock edge.
// Optional cascade taps serialOutR/serialOutL are built when USR_SERIAL_OUT_EN is defined.
module four_bit_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             serialIn,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] BlockIn,
  output logic [WIDTH-1:0] Out
`ifdef USR_SERIAL_OUT_EN
  ,
  output logic             serialOutR,
  output logic             serialOutL
`endif
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] cur,
                                                   input logic             sin);
    return {sin, cur[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] cur,
                                                  input logic             sin);
    return {cur[WIDTH-2:0], sin};
  endfunction

  // Any unknown sel value falls into the default branch and holds.
  always_comb begin
    reg_d = reg_q;
    case (sel)
      MODE_HOLD: reg_d = reg_q;
      MODE_SHR:  reg_d = shift_right(reg_q, serialIn);
      MODE_SHL:  reg_d = shift_left(reg_q, serialIn);
      MODE_LOAD: reg_d = BlockIn;
      default:   reg_d = reg_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign Out = reg_q;

`ifdef USR_SERIAL_OUT_EN
  assign serialOutR = reg_q[0];
  assign serialOutL = reg_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_four_bit_shift_reg.sv
// Self-checking bench for four_bit_shift_reg: directed scenarios plus randomized traffic
// against an arithmetic reference model. Also checks cascade taps when USR_SERIAL_OUT_EN is set.
module tb_four_bit_shift_reg;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         Clk;
  logic         Reset;
  logic         serialIn;
  logic [1:0]   sel;
  logic [W-1:0] BlockIn;
  logic [W-1:0] Out;
`ifdef USR_SERIAL_OUT_EN
  logic         serialOutR;
  logic         serialOutL;
`endif

  int n_checks;
  int n_fail;
  int model;

  four_bit_shift_reg #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .serialIn  (serialIn),
    .sel       (sel),
    .BlockIn   (BlockIn),
    .Out       (Out)
`ifdef USR_SERIAL_OUT_EN
    ,
    .serialOutR(serialOutR),
    .serialOutL(serialOutL)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: register treated as an integer in [0, 2^W).
  function automatic int model_next(input int cur, input bit rst, input int s,
                                    input bit sin, input int blk);
    if (rst) return 0;
    case (s)
      1: return (cur / 2) + (sin ? (1 << (W - 1)) : 0);
      2: return ((cur * 2) + (sin ? 1 : 0)) % (1 << W);
      3: return blk & MASK;
      default: return cur;
    endcase
  endfunction

  task automatic tick(input bit r, input logic [1:0] s, input bit si, input logic [W-1:0] b);
    Reset    = r;
    sel      = s;
    serialIn = si;
    BlockIn  = b;
    model    = model_next(model, r, int'(s), si, int'(b));
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 2'b00, 1'b1, 4'b1001);
    n_checks++;
    if (Out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_clear: Out=%b expected=%b", Out, 4'b0000);
    end
`ifdef USR_SERIAL_OUT_EN
    n_checks++;
    if (serialOutR !== 1'b0 || serialOutL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_taps: R=%b L=%b expected=0 0", serialOutR, serialOutL);
    end
`endif
    tick(1'b0, 2'b00, 1'b0, 4'b1001);
    n_checks++;
    if (Out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_hold: Out=%b expected=%b", Out, 4'b0000);
    end
  endtask

  task automatic test_shift_right();
    logic [W-1:0] exp_q[3];
    bit           sin_q[3];
    exp_q = '{4'b1000, 4'b0100, 4'b0010};
    sin_q = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b01, sin_q[i], 4'b0000);
      n_checks++;
      if (Out !== exp_q[i]) begin
        n_fail++;
        $display("FAIL shift_right[%0d]: Out=%b expected=%b", i, Out, exp_q[i]);
      end
`ifdef USR_SERIAL_OUT_EN
      n_checks++;
      if (serialOutR !== exp_q[i][0] || serialOutL !== exp_q[i][W-1]) begin
        n_fail++;
        $display("FAIL shift_right_taps[%0d]: R=%b L=%b expected=%b %b", i,
                 serialOutR, serialOutL, exp_q[i][0], exp_q[i][W-1]);
      end
`endif
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 2'b00, 1'b1, 4'b1111);
    n_checks++;
    if (Out !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold: Out=%b expected=%b", Out, 4'b0010);
    end
  endtask

  task automatic test_shift_left();
    logic [W-1:0] exp_q[3];
    bit           sin_q[3];
    exp_q = '{4'b0101, 4'b1010, 4'b0100};
    sin_q = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 2'b10, sin_q[i], 4'b0000);
      n_checks++;
      if (Out !== exp_q[i]) begin
        n_fail++;
        $display("FAIL shift_left[%0d]: Out=%b expected=%b", i, Out, exp_q[i]);
      end
`ifdef USR_SERIAL_OUT_EN
      n_checks++;
      if (serialOutR !== exp_q[i][0] || serialOutL !== exp_q[i][W-1]) begin
        n_fail++;
        $display("FAIL shift_left_taps[%0d]: R=%b L=%b expected=%b %b", i,
                 serialOutR, serialOutL, exp_q[i][0], exp_q[i][W-1]);
      end
`endif
    end
  endtask

  task automatic test_load();
    tick(1'b0, 2'b11, 1'b0, 4'b1001);
    n_checks++;
    if (Out !== 4'b1001) begin
      n_fail++;
      $display("FAIL load_a: Out=%b expected=%b", Out, 4'b1001);
    end
    tick(1'b0, 2'b11, 1'b1, 4'b1101);
    n_checks++;
    if (Out !== 4'b1101) begin
      n_fail++;
      $display("FAIL load_b: Out=%b expected=%b", Out, 4'b1101);
    end
    // Inputs wiggled between edges must not reach Out before the next edge.
    serialIn = 1'b0;
    sel      = 2'b01;
    BlockIn  = 4'b0000;
    #3;
    n_checks++;
    if (Out !== 4'b1101) begin
      n_fail++;
      $display("FAIL between_edges: Out=%b expected=%b", Out, 4'b1101);
    end
    sel = 2'b11;
    BlockIn = 4'b1101;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_priority();
    tick(1'b1, 2'b11, 1'b1, 4'b1111);
    n_checks++;
    if (Out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_priority: Out=%b expected=%b", Out, 4'b0000);
    end
  endtask

  task automatic test_traverse();
    tick(1'b0, 2'b01, 1'b1, 4'b0000);
    for (int i = 1; i < W; i++) tick(1'b0, 2'b01, 1'b0, 4'b0000);
    n_checks++;
    if (Out !== 4'b0001) begin
      n_fail++;
      $display("FAIL traverse_right: Out=%b expected=%b", Out, 4'b0001);
    end
    tick(1'b0, 2'b10, 1'b0, 4'b0000);
    for (int i = 1; i < W; i++) tick(1'b0, 2'b10, 1'b0, 4'b0000);
    n_checks++;
    if (Out !== 4'b0000) begin
      n_fail++;
      $display("FAIL traverse_left_out: Out=%b expected=%b", Out, 4'b0000);
    end
  endtask

  task automatic test_random();
    bit           r;
    logic [1:0]   s;
    bit           si;
    logic [W-1:0] b;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      s  = 2'($urandom_range(0, 3));
      si = 1'($urandom_range(0, 1));
      b  = W'($urandom);
      tick(r, s, si, b);
      n_checks++;
      if (Out !== W'(model)) begin
        n_fail++;
        $display("FAIL random[%0d]: rst=%0b sel=%b sin=%0b blk=%b Out=%b expected=%b",
                 i, r, s, si, b, Out, W'(model));
      end
`ifdef USR_SERIAL_OUT_EN
      n_checks++;
      if (serialOutR !== model[0] || serialOutL !== model[W-1]) begin
        n_fail++;
        $display("FAIL random_taps[%0d]: R=%b L=%b expected=%b %b", i,
                 serialOutR, serialOutL, model[0], model[W-1]);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model    = 0;
    Reset    = 1'b0;
    sel      = 2'b00;
    serialIn = 1'b0;
    BlockIn  = '0;
    test_reset();
    test_shift_right();
    test_hold();
    test_shift_left();
    test_load();
    test_reset_priority();
    test_traverse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
